// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: decoder state encoding, protocol prefix bytes,
// keyboard status bytes and the key-code width.
package ps2_pkg;

  localparam int unsigned KEY_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Bytes that follow the E1 prefix of the pause sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Mid-sequence idle timer.
//  clk, rst : clock and synchronous active-high reset
//  clear    : restart count at zero (takes priority over enable)
//  enable   : count this cycle
//  expired  : count has reached TIMEOUT_CYCLES-1 while enabled
module ps2_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + 1'b1;
  end

  assign expired = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code to key-event decoder.
//  clk, rst    : clock, synchronous active-high reset
//  rx_byte     : received scan-code byte, qualified by rx_valid
//  rx_valid    : one-cycle strobe per byte
//  rx_err      : one-cycle strobe, current byte is corrupt
//  last_change : {ext, code} of most recent make/break
//  key_valid   : one-cycle pulse when last_change/key_break update
//  key_break   : 1 = last event was a release
//  key_down    : per-key held bitmap indexed by 9-bit code
//  seq_err     : one-cycle pulse on aborted sequence
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  input  logic                 rx_err,
  output logic [KEY_W-1:0]     last_change,
  output logic                 key_valid,
  output logic                 key_break,
  output logic [2**KEY_W-1:0]  key_down,
  output logic                 seq_err
);

  ps2_state_e          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [KEY_W-1:0]    last_change_q, last_change_d;
  logic                key_valid_q, key_valid_d;
  logic                key_break_q, key_break_d;
  logic [2**KEY_W-1:0] key_down_q, key_down_d;
  logic                seq_err_q, seq_err_d;

  logic timer_clear, timer_en, timer_expired;
  logic emit, ev_ext, ev_brk;

  assign timer_clear = rx_valid || rx_err || (state_q == ST_IDLE);
  assign timer_en    = (state_q != ST_IDLE);

  ps2_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    skip_d        = skip_q;
    last_change_d = last_change_q;
    key_break_d   = key_break_q;
    key_down_d    = key_down_q;
    key_valid_d   = 1'b0;
    seq_err_d     = 1'b0;
    emit          = 1'b0;
    ev_ext        = 1'b0;
    ev_brk        = 1'b0;

    if (rx_err) begin
      state_d   = ST_IDLE;
      skip_d    = '0;
      seq_err_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_EXT) state_d = ST_EXT;
          else if (rx_byte == PS2_BRK) state_d = ST_BRK;
          else if (rx_byte == PS2_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else if (!is_status(rx_byte)) emit = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte == PS2_BRK) state_d = ST_EXT_BRK;
          else if (rx_byte != PS2_EXT) begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (rx_byte == PS2_EXT || rx_byte == PS2_BRK || rx_byte == PS2_PAUSE) begin
            seq_err_d = 1'b1;
          end else begin
            emit   = 1'b1;
            ev_brk = 1'b1;
            ev_ext = (state_q == ST_EXT_BRK);
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timer_expired) begin
      state_d   = ST_IDLE;
      skip_d    = '0;
      seq_err_d = 1'b1;
    end

    if (emit) begin
      last_change_d             = {ev_ext, rx_byte};
      key_break_d               = ev_brk;
      key_down_d[{ev_ext, rx_byte}] = !ev_brk;
      key_valid_d               = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      skip_q        <= '0;
      last_change_q <= '0;
      key_valid_q   <= 1'b0;
      key_break_q   <= 1'b0;
      key_down_q    <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      last_change_q <= last_change_d;
      key_valid_q   <= key_valid_d;
      key_break_q   <= key_break_d;
      key_down_q    <= key_down_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign last_change = last_change_q;
  assign key_valid   = key_valid_q;
  assign key_break   = key_break_q;
  assign key_down    = key_down_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench for ps2_key_event_decoder (TIMEOUT_CYCLES=16).
module tb_ps2_key_event_decoder;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_valid = 1'b0;
  logic         rx_err = 1'b0;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         key_break;
  logic [511:0] key_down;
  logic         seq_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pulses = 0;
  int unsigned n_seqerr = 0;

  // Reference model: prefix flags plus remaining pause bytes.
  logic [8:0]   m_last;
  logic         m_break, m_kv, m_se;
  logic [511:0] m_kd;
  logic         m_ext, m_brk;
  int unsigned  m_skip, m_idle;

  ps2_key_event_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
    .last_change (last_change),
    .key_valid   (key_valid),
    .key_break   (key_break),
    .key_down    (key_down),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_status_byte(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
           b == 8'h00 || b == 8'hFF;
  endfunction

  task automatic model_clear_seq();
    m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
  endtask

  task automatic model_emit(input logic ext, input logic brk, input logic [7:0] b);
    m_last  = {ext, b};
    m_break = brk;
    m_kd[{ext, b}] = !brk;
    m_kv    = 1;
  endtask

  task automatic model_update(input logic r, input logic v, input logic e, input logic [7:0] b);
    m_kv = 0; m_se = 0;
    if (r) begin
      m_last = '0; m_break = 0; m_kd = '0;
      model_clear_seq();
    end else if (e) begin
      m_se = 1;
      model_clear_seq();
    end else if (v) begin
      m_idle = 0;
      if (m_skip > 0) m_skip--;
      else if (m_brk) begin
        if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) m_se = 1;
        else model_emit(m_ext, 1'b1, b);
        model_clear_seq();
      end else if (m_ext) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b != 8'hE0) begin
          model_emit(1'b1, 1'b0, b);
          model_clear_seq();
        end
      end else begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else if (!is_status_byte(b)) model_emit(1'b0, 1'b0, b);
      end
    end else if (m_ext || m_brk || m_skip > 0) begin
      if (m_idle == TO - 1) begin
        m_se = 1;
        model_clear_seq();
      end else m_idle++;
    end else m_idle = 0;
  endtask

  // Drives one clock cycle, advances the model, samples #1 after the edge.
  task automatic step(input logic r, input logic v, input logic e, input logic [7:0] b);
    rst = r; rx_valid = v; rx_err = e; rx_byte = b;
    model_update(r, v, e, b);
    @(posedge clk);
    #1;
    rst = 0; rx_valid = 0; rx_err = 0;
    if (key_valid === 1'b1) n_pulses++;
    if (seq_err === 1'b1) n_seqerr++;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00);
    n_checks++;
    if (last_change !== 9'h000 || key_valid !== 1'b0 || key_break !== 1'b0 ||
        key_down !== '0 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got lc=%h kv=%b kb=%b kd_any=%b se=%b, want all 0",
               last_change, key_valid, key_break, |key_down, seq_err);
    end
  endtask

  task automatic test_make();
    step(0, 1, 0, 8'h1C);
    n_checks++;
    if (key_valid !== 1'b1 || last_change !== 9'h01C || key_break !== 1'b0 || key_down[9'h01C] !== 1'b1) begin
      n_fail++;
      $display("FAIL make_1C: got kv=%b lc=%h kb=%b kd=%b, want 1 01c 0 1",
               key_valid, last_change, key_break, key_down[9'h01C]);
    end
    step(0, 0, 0, 8'h00);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL make_pulse_width: got kv=%b want 0", key_valid);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [5];
    int unsigned p0;
    seq = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A};
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, seq[i]);
      if (i == 1) begin
        n_checks++;
        if (last_change !== 9'h15A || key_down[9'h15A] !== 1'b1 || key_break !== 1'b0) begin
          n_fail++;
          $display("FAIL ext_make: got lc=%h kd=%b kb=%b want 15a 1 0",
                   last_change, key_down[9'h15A], key_break);
        end
      end
    end
    n_checks++;
    if (key_down[9'h15A] !== 1'b0 || key_break !== 1'b1 || last_change !== 9'h15A) begin
      n_fail++;
      $display("FAIL ext_break: got lc=%h kd=%b kb=%b want 15a 0 1",
               last_change, key_down[9'h15A], key_break);
    end
    n_checks++;
    if (n_pulses - p0 != 2) begin
      n_fail++;
      $display("FAIL ext_pulses: got %0d want 2", n_pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    int unsigned p0;
    seq = '{8'h16, 8'h16, 8'hF0, 8'h16};
    p0 = n_pulses;
    for (int i = 0; i < 4; i++) step(0, 1, 0, seq[i]);
    n_checks++;
    if (n_pulses - p0 != 3 || key_down[9'h016] !== 1'b0 || key_break !== 1'b1) begin
      n_fail++;
      $display("FAIL typematic: got pulses=%0d kd=%b kb=%b want 3 0 1",
               n_pulses - p0, key_down[9'h016], key_break);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int unsigned p0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) step(0, 1, 0, seq[i]);
    n_checks++;
    if (n_pulses != p0 || key_down[9'h014] !== 1'b0 || key_down[9'h077] !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_silent: got pulses=%0d want 0", n_pulses - p0);
    end
    step(0, 1, 0, 8'h45);
    n_checks++;
    if (key_valid !== 1'b1 || last_change !== 9'h045 || key_break !== 1'b0) begin
      n_fail++;
      $display("FAIL after_pause: got kv=%b lc=%h want 1 045", key_valid, last_change);
    end
    p0 = n_pulses;
    step(0, 1, 0, 8'hAA);
    step(0, 0, 0, 8'h00);
    n_checks++;
    if (n_pulses != p0 || last_change !== 9'h045) begin
      n_fail++;
      $display("FAIL status_ignored: got pulses=%0d lc=%h want 0 045", n_pulses - p0, last_change);
    end
  endtask

  task automatic test_timeout();
    int unsigned s0;
    step(0, 1, 0, 8'hE0);
    s0 = n_seqerr;
    for (int i = 0; i < int'(TO) - 1; i++) step(0, 0, 0, 8'h00);
    n_checks++;
    if (n_seqerr != s0) begin
      n_fail++;
      $display("FAIL timeout_early: got %0d seq_err before limit want 0", n_seqerr - s0);
    end
    step(0, 0, 0, 8'h00);
    n_checks++;
    if (seq_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: got se=%b want 1", seq_err);
    end
    step(0, 1, 0, 8'h5A);
    n_checks++;
    if (last_change !== 9'h05A || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_timeout: got lc=%h kv=%b want 05a 1", last_change, key_valid);
    end
    step(0, 1, 1, 8'hF0);
    n_checks++;
    if (seq_err !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_err: got se=%b kv=%b want 1 0", seq_err, key_valid);
    end
    step(0, 1, 0, 8'h1C);
    n_checks++;
    if (key_break !== 1'b0 || last_change !== 9'h01C || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_rx_err: got lc=%h kb=%b kv=%b want 01c 0 1",
               last_change, key_break, key_valid);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1, 0, 8'hF0);
    step(1, 0, 0, 8'h00);
    n_checks++;
    if (last_change !== 9'h000 || key_valid !== 1'b0 || key_break !== 1'b0 ||
        key_down !== '0 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got lc=%h kv=%b kb=%b kd_any=%b se=%b want 0",
               last_change, key_valid, key_break, |key_down, seq_err);
    end
    step(0, 1, 0, 8'h1C);
    n_checks++;
    if (last_change !== 9'h01C || key_break !== 1'b0 || key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_make: got lc=%h kb=%b want 01c 0", last_change, key_break);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int unsigned r, gap;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 14)      b = 8'hE0;
      else if (r < 28) b = 8'hF0;
      else if (r < 32) b = 8'hE1;
      else if (r < 37) b = 8'hAA;
      else             b = 8'h10 + 8'($urandom_range(0, 15));
      r = $urandom_range(0, 99);
      if (r < 60)      gap = 0;
      else if (r < 92) gap = $urandom_range(1, 4);
      else             gap = $urandom_range(12, 20);
      for (int g = 0; g <= int'(gap); g++) begin
        if (g == int'(gap))
          step($urandom_range(0, 499) == 0, 1, $urandom_range(0, 49) == 0, b);
        else
          step(0, 0, 0, 8'h00);
        n_checks++;
        if (last_change !== m_last || key_valid !== m_kv || key_break !== m_break ||
            seq_err !== m_se || key_down !== m_kd) begin
          n_fail++;
          $display("FAIL random@%0t: got lc=%h kv=%b kb=%b se=%b kd=%h want lc=%h kv=%b kb=%b se=%b kd=%h",
                   $time, last_change, key_valid, key_break, seq_err, key_down,
                   m_last, m_kv, m_break, m_se, m_kd);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_make();
    test_extended();
    test_back_to_back();
    test_pause();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
